fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter SHALL be: RESET_PC, 32'h0000_1000, PC value loaded on reset.
REQ-002 Port SHALL be: clk  in  1  system clock, rising-edge active.
REQ-003 Port SHALL be: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port SHALL be: pc  out  32  current program counter.
REQ-005 Port SHALL be: imem_req  out  1  instruction memory read request.
REQ-006 Port SHALL be: imem_addr  out  32  read address, equal to pc.
REQ-007 Port SHALL be: imem_ack  in  1  read data valid, one-cycle pulse.
REQ-008 Port SHALL be: imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-009 Port SHALL be: instr  out  32  instruction held for core.
REQ-010 Port SHALL be: instr_pc  out  32  address of instr.
REQ-011 Port SHALL be: instr_valid  out  1  instr available to core.
REQ-012 Port SHALL be: instr_ready  in  1  core accepts/retires instr this cycle.
REQ-013 Port SHALL be: redirect  in  1  taken branch/jump, qualified by accept.
REQ-014 Port SHALL be: redirect_pc  in  32  branch/jump target.
REQ-015 Port SHALL be: halt  in  1  ecall/ebreak, qualified by accept.
REQ-016 Port SHALL be: resume  in  1  leave HALTED, one-cycle pulse.
REQ-017 Port SHALL be: halted  out  1  high in HALTED state.
REQ-018 Port SHALL be: misalign_err  out  1  sticky misaligned-target error.
REQ-019 Port SHALL be: instret  out  32  retired-instruction count.

Function
REQ-020 States SHALL be IDLE, FETCH, ISSUE, HALTED; IDLE -> FETCH unconditionally one cycle after reset release.
REQ-021 In FETCH, imem_req SHALL be 1 with imem_addr=pc held stable until imem_ack; on imem_ack: instr<=imem_rdata, instr_pc<=pc, -> ISSUE.
REQ-022 In ISSUE, instr_valid SHALL be 1 and instr/instr_pc stable until accept (instr_valid & instr_ready); imem_req=0.
REQ-023 On accept: pc<=redirect ? redirect_pc : pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0); instret<=instret+1 (wraps); -> HALTED if halt else FETCH.
REQ-024 Accept with redirect=1 and redirect_pc[1:0]!=0 SHALL: leave pc unchanged, not increment instret, set misalign_err, -> HALTED; overrides halt.
REQ-025 redirect, redirect_pc, halt SHALL be ignored when no accept occurs in that cycle.
REQ-026 In HALTED, resume=1 with misalign_err=0 SHALL -> FETCH next cycle; resume with misalign_err=1 ignored (reset only exit).
REQ-027 resume SHALL be ignored outside HALTED; imem_ack outside FETCH ignored.
REQ-028 Fetch-to-issue latency SHALL be one cycle after imem_ack; accept-to-next-imem_req one cycle.

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, instret=0, halted=0, misalign_err=0.
REQ-030 Reset during outstanding FETCH SHALL drop the request; a late imem_ack after release SHALL be ignored until FETCH re-entered.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum, PC increment constant (4), and default RESET_PC.
REQ-032 instret counter SHALL be a sub-module instret_ctr (clk, rst, inc, count).

Verification
REQ-033 Reset, ack after 1 wait cycle with 0x00500093, ready=1 -> imem_addr 0x1000, instr_pc 0x1000, then imem_addr 0x1004, instret 1.
REQ-034 Accept with redirect=1, redirect_pc=0x2000 -> next imem_addr 0x2000, instret increments.
REQ-035 Accept with halt=1 -> halted=1, pc=pc+4, no imem_req; resume pulse -> FETCH at that pc.
REQ-036 Accept with redirect_pc=0x2002 -> misalign_err=1, halted=1, pc unchanged; resume ignored.
REQ-037 instr_ready low 5 cycles in ISSUE -> instr/instr_pc stable, no new imem_req.
REQ-038 rst mid-FETCH then late imem_ack -> pc=0x1000, instr_valid=0, ack discarded.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the fetch FSM states, the sequential PC step and the default boot address.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;

    // Instructions are word aligned; any target with low bits set is illegal.
    function automatic logic isAligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instret_ctr.sv
// Retired-instruction counter: increments by one on each inc pulse, wrapping at 2^WIDTH.
module instret_ctr
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller: fetches one word at pc, holds it
// for the core until accepted, then advances/redirects/halts based on the accept.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        resume,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] instret
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         err_q, err_d;
    logic         retire;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        err_d      = err_q;
        retire     = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // A misaligned redirect is fatal: it wins over halt and does not retire.
                if (instr_ready) begin
                    if (redirect && !isAligned(redirect_pc)) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                    end else begin
                        pc_d    = redirect ? redirect_pc : (pc_q + PC_INC);
                        retire  = 1'b1;
                        state_d = halt ? HALTED : FETCH;
                    end
                end
            end
            HALTED: begin
                if (resume && !err_q) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            err_q      <= err_d;
        end
    end

    instret_ctr #(
        .WIDTH (32)
    ) u_instret_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .count (instret)
    );

    assign pc           = pc_q;
    assign imem_addr    = pc_q;
    assign imem_req     = (state_q == FETCH);
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign instr_valid  = (state_q == ISSUE);
    assign halted       = (state_q == HALTED);
    assign misalign_err = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a table of fetch/accept transactions with a
// scoreboard of expected issued words, followed by reset and misalignment sequences.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        resume;
    logic        halted;
    logic        misalign_err;
    logic [31:0] instret;

    fetch_ctrl #(
        .RESET_PC (32'h0000_1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .resume       (resume),
        .halted       (halted),
        .misalign_err (misalign_err),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ackWait;
        logic [31:0] rdata;
        logic        redirect;
        logic [31:0] redirectPc;
        logic        halt;
        int          readyDelay;
        logic [31:0] expAddr;
        logic [31:0] expNextPc;
        logic [31:0] expInstret;
        logic        expHalted;
        logic        expMisalign;
    } vec_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
    } issue_t;

    vec_t   vecs[7];
    issue_t scoreboard[$];
    int     checks = 0;
    int     errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One transaction: fetch at the expected address, issue, optional stall, accept.
    task automatic applyStimulus(input int idx);
        vec_t        v;
        issue_t      exp;
        logic [31:0] heldInstr;
        logic [31:0] heldPc;
        int          n;
        v = vecs[idx];
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            checkOutput($sformatf("v%0d_req_timeout", idx), 32'(imem_req), 32'd1);
            return;
        end
        checkOutput($sformatf("v%0d_imem_addr", idx), imem_addr, v.expAddr);
        scoreboard.push_back('{word: v.rdata, addr: v.expAddr});
        for (int k = 0; k < v.ackWait; k++) begin
            @(negedge clk);
            checkOutput($sformatf("v%0d_req_held", idx), {31'd0, imem_req}, 32'd1);
            checkOutput($sformatf("v%0d_addr_held", idx), imem_addr, v.expAddr);
        end
        imem_ack   = 1'b1;
        imem_rdata = v.rdata;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        checkOutput($sformatf("v%0d_issue_latency", idx), {31'd0, instr_valid}, 32'd1);
        checkOutput($sformatf("v%0d_req_dropped", idx), {31'd0, imem_req}, 32'd0);
        if (instr_valid && scoreboard.size() > 0) begin
            exp = scoreboard.pop_front();
            checkOutput($sformatf("v%0d_instr", idx), instr, exp.word);
            checkOutput($sformatf("v%0d_instr_pc", idx), instr_pc, exp.addr);
        end
        heldInstr = instr;
        heldPc    = instr_pc;
        // Stall with decoy redirect/halt and a stray ack; none may take effect.
        for (int d = 0; d < v.readyDelay; d++) begin
            instr_ready = 1'b0;
            redirect    = 1'b1;
            redirect_pc = 32'h0000_3000;
            halt        = 1'b1;
            imem_ack    = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            checkOutput($sformatf("v%0d_stall_valid", idx), {31'd0, instr_valid}, 32'd1);
            checkOutput($sformatf("v%0d_stall_instr", idx), instr, heldInstr);
            checkOutput($sformatf("v%0d_stall_pc", idx), instr_pc, heldPc);
            checkOutput($sformatf("v%0d_stall_noreq", idx), {31'd0, imem_req}, 32'd0);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        redirect    = v.redirect;
        redirect_pc = v.redirectPc;
        halt        = v.halt;
        @(negedge clk);
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        checkOutput($sformatf("v%0d_pc", idx), pc, v.expNextPc);
        checkOutput($sformatf("v%0d_instret", idx), instret, v.expInstret);
        checkOutput($sformatf("v%0d_halted", idx), {31'd0, halted}, {31'd0, v.expHalted});
        checkOutput($sformatf("v%0d_misalign", idx), {31'd0, misalign_err}, {31'd0, v.expMisalign});
        checkOutput($sformatf("v%0d_next_req", idx), {31'd0, imem_req}, {31'd0, !v.expHalted});
        if (v.expHalted && !v.expMisalign) begin
            @(negedge clk);
            checkOutput($sformatf("v%0d_halt_noreq", idx), {31'd0, imem_req}, 32'd0);
            resume = 1'b1;
            @(negedge clk);
            resume = 1'b0;
            checkOutput($sformatf("v%0d_resume_req", idx), {31'd0, imem_req}, 32'd1);
            checkOutput($sformatf("v%0d_resume_addr", idx), imem_addr, v.expNextPc);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{1, 32'h0050_0093, 1'b0, 32'h0,         1'b0, 0, 32'h0000_1000, 32'h0000_1004, 32'd1, 1'b0, 1'b0};
        vecs[1] = '{0, 32'h0010_0113, 1'b1, 32'h0000_2000, 1'b0, 0, 32'h0000_1004, 32'h0000_2000, 32'd2, 1'b0, 1'b0};
        vecs[2] = '{2, 32'h0020_81b3, 1'b0, 32'h0,         1'b0, 5, 32'h0000_2000, 32'h0000_2004, 32'd3, 1'b0, 1'b0};
        vecs[3] = '{0, 32'h0000_0073, 1'b0, 32'h0,         1'b1, 0, 32'h0000_2004, 32'h0000_2008, 32'd4, 1'b1, 1'b0};
        vecs[4] = '{0, 32'h0000_0013, 1'b1, 32'hFFFF_FFFC, 1'b0, 0, 32'h0000_2008, 32'hFFFF_FFFC, 32'd5, 1'b0, 1'b0};
        vecs[5] = '{0, 32'h1111_1111, 1'b0, 32'h0,         1'b0, 1, 32'hFFFF_FFFC, 32'h0000_0000, 32'd6, 1'b0, 1'b0};
        vecs[6] = '{1, 32'h2222_2222, 1'b1, 32'h0000_2002, 1'b1, 0, 32'h0000_0000, 32'h0000_0000, 32'd6, 1'b1, 1'b1};

        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        resume      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_pc", pc, 32'h0000_1000);
        checkOutput("reset_req", {31'd0, imem_req}, 32'd0);
        checkOutput("reset_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("reset_instret", instret, 32'd0);
        checkOutput("reset_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(i);
        end

        // Misaligned halt is sticky: resume must not restart fetching.
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("misalign_resume_halted", {31'd0, halted}, 32'd1);
        checkOutput("misalign_resume_noreq", {31'd0, imem_req}, 32'd0);
        checkOutput("misalign_resume_pc", pc, 32'h0000_0000);

        // Asynchronous reset mid-cycle clears everything immediately.
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_pc", pc, 32'h0000_1000);
        checkOutput("async_rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("async_rst_misalign", {31'd0, misalign_err}, 32'd0);
        checkOutput("async_rst_instret", instret, 32'd0);
        checkOutput("async_rst_instr", instr, 32'd0);
        checkOutput("async_rst_instr_pc", instr_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("refetch_req", {31'd0, imem_req}, 32'd1);
        checkOutput("refetch_addr", imem_addr, 32'h0000_1000);

        // Reset with the request outstanding, then a late ack during the IDLE cycle.
        #2 rst = 1'b1;
        #1;
        checkOutput("midfetch_rst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        checkOutput("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("late_ack_instr", instr, 32'd0);
        checkOutput("late_ack_pc", pc, 32'h0000_1000);
        checkOutput("late_ack_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        checkOutput("late_ack_still_invalid", {31'd0, instr_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
